// File: rtl/sc_bs2bin_pkg.sv
// Shared stochastic-computing definitions: default widths, FSM encoding,
// popcount width and a saturating adder used by the decoder.
package sc_bs2bin_pkg;

  localparam int IN_WIDTH_DEF  = 32;
  localparam int ACC_WIDTH_DEF = 16;
  localparam int LEN_WIDTH_DEF = 8;

  // Working width of the saturating adder; accumulators must be narrower.
  localparam int SAT_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // Bits needed to hold a ones-count of a w-bit word (0..w inclusive).
  function automatic int pc_width(input int w);
    return $clog2(w + 1);
  endfunction

  // a + b clamped to max; operands are zero-extended by the caller.
  function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                               input logic [SAT_W-1:0] b,
                                               input logic [SAT_W-1:0] max);
    logic [SAT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s > {1'b0, max}) begin
      return max;
    end
    return s[SAT_W-1:0];
  endfunction

endpackage

// File: rtl/sc_bs2bin_if.sv
// Input word stream and result handshake of the stochastic-to-binary decoder.
interface sc_bs2bin_if
  import sc_bs2bin_pkg::*;
#(
  parameter int IN_WIDTH  = IN_WIDTH_DEF,
  parameter int ACC_WIDTH = ACC_WIDTH_DEF,
  parameter int LEN_WIDTH = LEN_WIDTH_DEF
) ();

  logic                 in_valid;
  logic                 in_ready;
  logic [IN_WIDTH-1:0]  in_data;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_data;
  logic [LEN_WIDTH-1:0] out_len;

  // Producer of bitstream words and consumer of results.
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_len
  );

  // The decoder itself.
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_len
  );

endinterface

// File: rtl/sc_popcount.sv
// Combinational ones-count of a bitstream word as a balanced adder tree.
// The word is zero-padded to a power of two; each level halves the node count.
module sc_popcount
  import sc_bs2bin_pkg::*;
#(
  parameter int IN_WIDTH = IN_WIDTH_DEF
) (
  input  logic [IN_WIDTH-1:0]           in_data,
  output logic [pc_width(IN_WIDTH)-1:0] count
);

  localparam int PCW = pc_width(IN_WIDTH);
  localparam int LVL = $clog2(IN_WIDTH);
  localparam int NP  = 1 << LVL;

  genvar gl, gi;
  generate
    for (gl = 0; gl <= LVL; gl++) begin : g_lvl
      localparam int N = NP >> gl;
      logic [PCW-1:0] s [N];
      for (gi = 0; gi < N; gi++) begin : g_node
        if (gl == 0) begin : g_leaf
          if (gi < IN_WIDTH) begin : g_bit
            assign s[gi] = PCW'(in_data[gi]);
          end else begin : g_pad
            assign s[gi] = '0;
          end
        end else begin : g_sum
          assign s[gi] = g_lvl[gl-1].s[2*gi] + g_lvl[gl-1].s[2*gi+1];
        end
      end
    end
  endgenerate

  assign count = g_lvl[LVL].s[0];

endmodule

// File: rtl/sc_bs2bin.sv
// Stochastic-to-binary decoder. Stage 1 registers the popcount of each
// accepted word; stage 2 accumulates counts and word totals (saturating) and
// at frame end publishes the result over a valid/ready handshake. Input is
// blocked from the last word of a frame until the result has been consumed.
module sc_bs2bin
  import sc_bs2bin_pkg::*;
#(
  parameter int IN_WIDTH  = IN_WIDTH_DEF,
  parameter int ACC_WIDTH = ACC_WIDTH_DEF,
  parameter int LEN_WIDTH = LEN_WIDTH_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  sc_bs2bin_if.slave   bus
);

  localparam int PC_WIDTH = pc_width(IN_WIDTH);
  localparam logic [SAT_W-1:0] ACC_MAX = SAT_W'({ACC_WIDTH{1'b1}});
  localparam logic [SAT_W-1:0] LEN_MAX = SAT_W'({LEN_WIDTH{1'b1}});

  state_t               state_q, state_d;
  logic                 run_q;
  logic [PC_WIDTH-1:0]  pc_q, pc_d;
  logic                 pc_vld_q, pc_vld_d;
  logic                 pc_last_q, pc_last_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic [ACC_WIDTH-1:0] out_data_q, out_data_d;
  logic [LEN_WIDTH-1:0] out_len_q, out_len_d;
  logic                 out_valid_q, out_valid_d;

  logic [PC_WIDTH-1:0]  pc_count;
  logic [ACC_WIDTH-1:0] sum;
  logic [LEN_WIDTH-1:0] len;
  logic                 in_ready;
  logic                 accept;

  sc_popcount #(.IN_WIDTH(IN_WIDTH)) u_popcount (
    .in_data (bus.in_data),
    .count   (pc_count)
  );

  // Ready only once out of reset, with no result pending or in flight.
  assign in_ready = run_q && !out_valid_q && !(pc_vld_q && pc_last_q);
  assign accept   = bus.in_valid && in_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_len   = out_len_q;

  // Stage 1: capture the popcount and frame-end flag of an accepted word.
  always_comb begin
    pc_d      = pc_q;
    pc_last_d = pc_last_q;
    pc_vld_d  = accept;
    if (accept) begin
      pc_d      = pc_count;
      pc_last_d = bus.in_last;
    end
  end

  // Stage 2: saturating accumulate, or publish and clear at frame end.
  always_comb begin
    sum         = ACC_WIDTH'(sat_add(SAT_W'(acc_q), SAT_W'(pc_q), ACC_MAX));
    len         = LEN_WIDTH'(sat_add(SAT_W'(cnt_q), SAT_W'(1), LEN_MAX));
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_len_d   = out_len_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    if (pc_vld_q) begin
      if (pc_last_q) begin
        out_data_d  = sum;
        out_len_d   = len;
        out_valid_d = 1'b1;
        acc_d       = '0;
        cnt_d       = '0;
      end else begin
        acc_d = sum;
        cnt_d = len;
      end
    end
  end

  // Frame-tracking FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pc_vld_q && pc_last_q) begin
          state_d = ST_HOLD;
        end else if (accept && !bus.in_last) begin
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (pc_vld_q && pc_last_q) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_valid_q && bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset discards any partial frame and pending result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      run_q       <= 1'b0;
      pc_q        <= '0;
      pc_vld_q    <= 1'b0;
      pc_last_q   <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_len_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_q       <= 1'b1;
      pc_q        <= pc_d;
      pc_vld_q    <= pc_vld_d;
      pc_last_q   <= pc_last_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_len_q   <= out_len_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_sc_bs2bin.sv
// Directed and randomized bench for sc_bs2bin: a default-width instance and
// a narrow instance for saturation, checked against frame-level expectations.
module tb_sc_bs2bin;
  import sc_bs2bin_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  sc_bs2bin_if #(.IN_WIDTH(32), .ACC_WIDTH(16), .LEN_WIDTH(8)) b0 ();
  sc_bs2bin_if #(.IN_WIDTH(32), .ACC_WIDTH(8),  .LEN_WIDTH(2)) b1 ();

  sc_bs2bin #(.IN_WIDTH(32), .ACC_WIDTH(16), .LEN_WIDTH(8)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b0.slave)
  );

  sc_bs2bin #(.IN_WIDTH(32), .ACC_WIDTH(8), .LEN_WIDTH(2)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a word to dut0 and return just after the edge that accepts it.
  task automatic push0(input logic [31:0] w, input logic last);
    int k;
    b0.in_valid = 1'b1;
    b0.in_data  = w;
    b0.in_last  = last;
    k = 0;
    while (!b0.in_ready && k < 50) begin
      step();
      k++;
    end
    if (k >= 50) chk("push0_ready_timeout", 32'd0, 32'd1);
    step();
  endtask

  task automatic push1(input logic [31:0] w, input logic last);
    int k;
    b1.in_valid = 1'b1;
    b1.in_data  = w;
    b1.in_last  = last;
    k = 0;
    while (!b1.in_ready && k < 50) begin
      step();
      k++;
    end
    if (k >= 50) chk("push1_ready_timeout", 32'd0, 32'd1);
    step();
  endtask

  // Drop valid; drive junk data and in_last, which must be ignored.
  task automatic idle0();
    b0.in_valid = 1'b0;
    b0.in_data  = $urandom;
    b0.in_last  = 1'b1;
  endtask

  // Wait for dut0's result, check it, and check valid drops after handshake.
  task automatic expect0(input string tag, input int ed, input int el);
    int k;
    k = 0;
    while (!b0.out_valid && k < 30) begin
      step();
      k++;
    end
    chk({tag, "_valid"}, 32'(b0.out_valid), 32'd1);
    chk({tag, "_data"}, 32'(b0.out_data), 32'(ed));
    chk({tag, "_len"}, 32'(b0.out_len), 32'(el));
    $display("frame %s: out_data=%0d out_len=%0d (expect %0d/%0d)", tag, b0.out_data, b0.out_len, ed, el);
    if (b0.out_ready) begin
      step();
      chk({tag, "_valid_drop"}, 32'(b0.out_valid), 32'd0);
      chk({tag, "_ready_back"}, 32'(b0.in_ready), 32'd1);
    end
  endtask

  initial begin
    logic [31:0] words [$];
    int exp_sum, exp_len, nw, k;

    n_checks = 0;
    n_pass   = 0;
    rst_n = 1'b0;
    b0.in_valid = 1'b0; b0.in_data = '0; b0.in_last = 1'b0; b0.out_ready = 1'b1;
    b1.in_valid = 1'b0; b1.in_data = '0; b1.in_last = 1'b0; b1.out_ready = 1'b1;

    // Reset state.
    step();
    step();
    chk("rst_in_ready", 32'(b0.in_ready), 32'd0);
    chk("rst_out_valid", 32'(b0.out_valid), 32'd0);
    chk("rst_out_data", 32'(b0.out_data), 32'd0);
    chk("rst_out_len", 32'(b0.out_len), 32'd0);
    rst_n = 1'b1;
    step();
    step();
    chk("post_rst_in_ready", 32'(b0.in_ready), 32'd1);

    // Single full word: exact two-cycle latency.
    push0(32'hFFFF_FFFF, 1'b1);
    idle0();
    chk("lat_t1_no_valid", 32'(b0.out_valid), 32'd0);
    chk("lat_t1_in_ready", 32'(b0.in_ready), 32'd0);
    step();
    chk("lat_t2_valid", 32'(b0.out_valid), 32'd1);
    expect0("single", 32, 1);

    // Back-to-back two-word frame, then an immediate one-word frame.
    push0(32'h0000_FFFF, 1'b0);
    push0(32'h0000_00FF, 1'b1);
    idle0();
    expect0("two_word", 24, 2);
    push0(32'h0000_0001, 1'b1);
    idle0();
    expect0("after_clear", 1, 1);

    // All-zero words still count toward the length.
    push0(32'h0, 1'b0);
    push0(32'h0, 1'b1);
    idle0();
    expect0("zeros", 0, 2);

    // Backpressure: result held and input blocked until consumed.
    b0.out_ready = 1'b0;
    push0(32'hAAAA_AAAA, 1'b0);
    push0(32'h0000_0001, 1'b1);
    idle0();
    k = 0;
    while (!b0.out_valid && k < 30) begin
      step();
      k++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(b0.out_valid), 32'd1);
      chk("bp_data", 32'(b0.out_data), 32'd17);
      chk("bp_len", 32'(b0.out_len), 32'd2);
      chk("bp_in_ready", 32'(b0.in_ready), 32'd0);
      step();
    end
    b0.out_ready = 1'b1;
    step();
    chk("bp_valid_drop", 32'(b0.out_valid), 32'd0);
    chk("bp_ready_back", 32'(b0.in_ready), 32'd1);
    $display("frame backpressure: held out_data=17 out_len=2 for 5 cycles");

    // Saturation on the narrow instance.
    for (int i = 0; i < 9; i++) push1(32'hFFFF_FFFF, i == 8);
    b1.in_valid = 1'b0;
    k = 0;
    while (!b1.out_valid && k < 30) begin
      step();
      k++;
    end
    chk("sat_valid", 32'(b1.out_valid), 32'd1);
    chk("sat_data", 32'(b1.out_data), 32'd255);
    chk("sat_len", 32'(b1.out_len), 32'd3);
    $display("frame saturate: out_data=%0d out_len=%0d", b1.out_data, b1.out_len);
    step();

    // Gapped input mid-frame.
    push0(32'hF0F0_F0F0, 1'b0);
    idle0();
    step(); step(); step();
    push0(32'h0F0F_0F0F, 1'b1);
    idle0();
    expect0("gapped", 32, 2);

    // Randomized frames against a popcount model.
    for (int f = 0; f < 12; f++) begin
      words.delete();
      nw = $urandom_range(1, 6);
      for (int i = 0; i < nw; i++) words.push_back($urandom);
      exp_sum = 0;
      foreach (words[i]) exp_sum += $countones(words[i]);
      exp_len = (words.size() > 255) ? 255 : words.size();
      if (exp_sum > 65535) exp_sum = 65535;
      for (int i = 0; i < nw; i++) begin
        push0(words[i], i == nw - 1);
        if ($urandom_range(0, 2) == 0) begin
          idle0();
          step();
        end
      end
      idle0();
      expect0($sformatf("rand%0d", f), exp_sum, exp_len);
    end

    // Reset mid-frame discards partial state.
    push0(32'hFFFF_FFFF, 1'b0);
    push0(32'hFFFF_FFFF, 1'b0);
    idle0();
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(b0.out_valid), 32'd0);
    chk("midrst_data", 32'(b0.out_data), 32'd0);
    chk("midrst_len", 32'(b0.out_len), 32'd0);
    chk("midrst_in_ready", 32'(b0.in_ready), 32'd0);
    chk("midrst_sat_data", 32'(b1.out_data), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    step();
    push0(32'h0000_0003, 1'b1);
    idle0();
    expect0("after_reset", 2, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
